// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO
//
// Accepts MULT/MULTU/DIV/DIVU (multi-cycle, fixed latency) and MTHI/MTLO
// (zero latency). The result is computed on the start edge, parked in
// pending registers, and committed to HI/LO when the busy counter expires.
//
// Ports:
//   clk      in   posedge clock
//   reset    in   synchronous active-low reset
//   op       in   4-bit E-stage MDU op (1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others NONE)
//   rs_val   in   forwarded rs operand
//   rt_val   in   forwarded rt operand
//   d_is_md  in   D-stage instruction is an MDU op
//   busy     out  operation in flight
//   stall    out  freeze F/D for a D-stage MDU op
//   hi, lo   out  architectural HI/LO
//   rd_data  out  MFHI/MFLO read value, 0 otherwise
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic          pwe_q, pwe_d;   // pending result should be committed (0 for divide-by-zero)

    logic          start;
    logic          is_mdu_start_op;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   div_b;          // divisor forced nonzero so the dividers never see 0
    logic [31:0]   mag_a, mag_b;
    logic [31:0]   mag_q, mag_r;
    logic [31:0]   sdiv_q, sdiv_r;
    logic [31:0]   udiv_q, udiv_r;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    assign div_b  = (rt_val == 32'd0) ? 32'd1 : rt_val;

    // Signed divide via magnitudes: keeps 0x80000000 / 0xffffffff well defined
    // (magnitude 0x80000000 / 1, signs equal -> quotient 0x80000000, remainder 0).
    assign mag_a  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign mag_b  = div_b[31]  ? (32'd0 - div_b)  : div_b;
    assign mag_q  = mag_a / mag_b;
    assign mag_r  = mag_a % mag_b;
    assign sdiv_q = (rs_val[31] ^ div_b[31]) ? (32'd0 - mag_q) : mag_q;
    assign sdiv_r = rs_val[31] ? (32'd0 - mag_r) : mag_r;

    assign udiv_q = rs_val / div_b;
    assign udiv_r = rs_val % div_b;

    assign busy            = (cnt_q != '0);
    assign is_mdu_start_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign start           = is_mdu_start_op && !busy;
    assign stall           = d_is_md && (start || busy);

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        rd_data = 32'd0;
        if (op == OP_MFHI) begin
            rd_data = hi_q;
        end else if (op == OP_MFLO) begin
            rd_data = lo_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        pwe_d = pwe_q;

        if (busy) begin
            // Every op 1-6 is ignored here; only the countdown advances.
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && pwe_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (start) begin
            unique case (op)
                OP_MULT: begin
                    cnt_d = CW'(MULT_CYCLES);
                    phi_d = prod_s[63:32];
                    plo_d = prod_s[31:0];
                    pwe_d = 1'b1;
                end
                OP_MULTU: begin
                    cnt_d = CW'(MULT_CYCLES);
                    phi_d = prod_u[63:32];
                    plo_d = prod_u[31:0];
                    pwe_d = 1'b1;
                end
                OP_DIV: begin
                    cnt_d = CW'(DIV_CYCLES);
                    phi_d = sdiv_r;
                    plo_d = sdiv_q;
                    pwe_d = (rt_val != 32'd0);
                end
                default: begin
                    cnt_d = CW'(DIV_CYCLES);
                    phi_d = udiv_r;
                    plo_d = udiv_q;
                    pwe_d = (rt_val != 32'd0);
                end
            endcase
        end else if (op == OP_MTHI) begin
            hi_d = rs_val;
        end else if (op == OP_MTLO) begin
            lo_d = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            phi_q <= 32'd0;
            plo_q <= 32'd0;
            pwe_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            pwe_q <= pwe_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed-vector bench for mdu_ctrl
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int tests_run;
    int tests_failed;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; d_is_md = 1'b0;
        step(); step();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0) begin tests_failed++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); end
        tests_run++;
        if (stall !== 1'b0 || rd_data !== 32'd0) begin tests_failed++; $display("FAIL reset_stall_rd: got %b/%h expected 0/0", stall, rd_data); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int busy_cnt;
        busy_cnt = 0;
        op = 4'd1; rs_val = 32'h00000003; rt_val = 32'hfffffffe;
        step();
        op = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (busy === 1'b1) busy_cnt++;
            // MTHI while busy must be dropped
            op = (i == 1) ? 4'd5 : 4'd0;
            rs_val = 32'hdeadbeef;
            step();
        end
        op = 4'd0;
        tests_run++;
        if (busy_cnt != 5) begin tests_failed++; $display("FAIL mult_busy_cycles: got %0d expected 5", busy_cnt); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mult_done_busy: got %b expected 0", busy); end
        tests_run++;
        if (hi !== 32'hffffffff || lo !== 32'hfffffffa) begin tests_failed++; $display("FAIL mult_result: got %h/%h expected ffffffff/fffffffa", hi, lo); end
    endtask

    task automatic test_multu_stall();
        int stall_cnt;
        stall_cnt = 0;
        d_is_md = 1'b1;
        op = 4'd2; rs_val = 32'hffffffff; rt_val = 32'h00000002;
        #1;
        if (stall === 1'b1) stall_cnt++;
        step();
        op = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (stall === 1'b1) stall_cnt++;
            step();
        end
        tests_run++;
        if (stall_cnt != 6) begin tests_failed++; $display("FAIL multu_stall_cycles: got %0d expected 6", stall_cnt); end
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL multu_stall_after: got %b expected 0", stall); end
        tests_run++;
        if (hi !== 32'h00000001 || lo !== 32'hfffffffe) begin tests_failed++; $display("FAIL multu_result: got %h/%h expected 00000001/fffffffe", hi, lo); end
        d_is_md = 1'b0;
    endtask

    task automatic run_div(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b, output int nbusy);
        nbusy = 0;
        op = dop; rs_val = a; rt_val = b;
        step();
        op = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b1) break;
            nbusy++;
            step();
        end
    endtask

    task automatic test_div();
        int nb;
        run_div(4'd3, 32'hfffffff9, 32'h00000002, nb);
        tests_run++;
        if (nb != 10) begin tests_failed++; $display("FAIL div_busy_cycles: got %0d expected 10", nb); end
        tests_run++;
        if (lo !== 32'hfffffffd || hi !== 32'hffffffff) begin tests_failed++; $display("FAIL div_result: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo); end
        run_div(4'd4, 32'hfffffff9, 32'h00000002, nb);
        tests_run++;
        if (lo !== 32'h7ffffffc || hi !== 32'h00000001) begin tests_failed++; $display("FAIL divu_result: got hi=%h lo=%h expected hi=00000001 lo=7ffffffc", hi, lo); end
        run_div(4'd3, 32'h80000000, 32'hffffffff, nb);
        tests_run++;
        if (lo !== 32'h80000000 || hi !== 32'h00000000) begin tests_failed++; $display("FAIL div_overflow: got hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo); end
    endtask

    task automatic test_div_zero();
        int nb;
        op = 4'd6; rs_val = 32'h0badf00d;
        step();
        op = 4'd5; rs_val = 32'h12345678;
        step();
        op = 4'd0;
        tests_run++;
        if (hi !== 32'h12345678 || lo !== 32'h0badf00d || busy !== 1'b0) begin tests_failed++; $display("FAIL mt_write: got hi=%h lo=%h busy=%b expected 12345678/0badf00d/0", hi, lo, busy); end
        run_div(4'd3, 32'h00000005, 32'h00000000, nb);
        tests_run++;
        if (nb != 10) begin tests_failed++; $display("FAIL divzero_busy_cycles: got %0d expected 10", nb); end
        tests_run++;
        if (hi !== 32'h12345678 || lo !== 32'h0badf00d) begin tests_failed++; $display("FAIL divzero_unchanged: got hi=%h lo=%h expected 12345678/0badf00d", hi, lo); end
        op = 4'd7; #1;
        tests_run++;
        if (rd_data !== 32'h12345678) begin tests_failed++; $display("FAIL mfhi_read: got %h expected 12345678", rd_data); end
        op = 4'd8; #1;
        tests_run++;
        if (rd_data !== 32'h0badf00d) begin tests_failed++; $display("FAIL mflo_read: got %h expected 0badf00d", rd_data); end
        op = 4'hf; rs_val = 32'h55555555;
        step();
        tests_run++;
        if (rd_data !== 32'd0 || hi !== 32'h12345678 || busy !== 1'b0) begin tests_failed++; $display("FAIL op_none_15: got rd=%h hi=%h busy=%b expected 0/12345678/0", rd_data, hi, busy); end
        op = 4'd0;
    endtask

    task automatic test_reset_midflight();
        op = 4'd1; rs_val = 32'd7; rt_val = 32'd9;
        step();
        op = 4'd0;
        step(); step();
        reset = 1'b0;
        step();
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midflight_reset: got hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy); end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0) begin tests_failed++; $display("FAIL no_late_write: got hi=%h lo=%h expected 0/0", hi, lo); end
        reset = 1'b0; op = 4'd1; rs_val = 32'd7; rt_val = 32'd9;
        step();
        reset = 1'b1; op = 4'd0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_with_reset: got busy=%b expected 0", busy); end
        for (int i = 0; i < 6; i++) step();
        tests_run++;
        if (lo !== 32'd0) begin tests_failed++; $display("FAIL start_with_reset_lo: got %h expected 0", lo); end
    endtask

    task automatic test_back_to_back();
        int nb;
        nb = 0;
        d_is_md = 1'b1;
        op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
        step();
        op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (busy !== 1'b0 || stall !== 1'b1) begin tests_failed++; $display("FAIL b2b_completion_cycle: got busy=%b stall=%b expected 0/1", busy, stall); end
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd6) begin tests_failed++; $display("FAIL b2b_mult_only: got hi=%h lo=%h expected 00000000/00000006", hi, lo); end
        step();
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b1) break;
            nb++;
            if (nb == 10) op = 4'd0;
            step();
        end
        d_is_md = 1'b0;
        tests_run++;
        if (nb != 10) begin tests_failed++; $display("FAIL b2b_div_busy: got %0d expected 10", nb); end
        tests_run++;
        if (hi !== 32'd2 || lo !== 32'd14) begin tests_failed++; $display("FAIL b2b_div_result: got hi=%h lo=%h expected 00000002/0000000e", hi, lo); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        #2;
        test_reset();
        test_mult();
        test_multu_stall();
        test_div();
        test_div_zero();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
